// File: rtl/dso_cap_pkg.sv
// Shared constants and types for the DSO acquisition front end.
package dso_cap_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned DEC_W  = 4;
  localparam int unsigned DCNT_W = 2 ** DEC_W;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } cap_state_e;

endpackage

// File: rtl/trig_detect.sv
// Trigger source select, 2-FF synchronizer and registered single-cycle edge detect.
module trig_detect
  import dso_cap_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic trig1,
  input  logic trig2,
  input  logic src_sel,
  input  logic edge_sel,
  output logic trig_det
);

  logic raw_c;
  logic sync1_q, sync2_q, prev_q;

  assign raw_c = src_sel ? trig2 : trig1;

  // sync2_q is the first metastability-safe stage; prev_q holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      trig_det <= 1'b0;
    end else begin
      sync1_q  <= raw_c;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      trig_det <= (edge_sel == EDGE_FALL) ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);
    end
  end

endmodule

// File: rtl/dso_capture_ctrl.sv
// Circular pre/post-trigger capture controller driving the shared sample RAMs,
// with host read passthrough while idle.
module dso_capture_ctrl
  import dso_cap_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              adc_clk,
  input  logic              trig1,
  input  logic              trig2,
  input  logic              trig_src,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic              cap_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              cap_done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr
);

  cap_state_e state_q, state_d;

  logic [DCNT_W-1:0] dec_cnt_q;
  logic [DEC_W-1:0]  dec_q;
  logic              src_q, edge_q;
  logic [ADDR_W-1:0] post_len_q;
  logic [ADDR_W-1:0] wptr_q, cnt_q;
  logic              st_en_q;
  logic [ADDR_W-1:0] st_addr_q;
  logic              trig_det;

  logic              smp_c, idle_c, start_c, store_c, pre_last_c;
  logic [DCNT_W-1:0] dec_mask_c;
  logic [ADDR_W-1:0] p_c;

  trig_detect u_trig (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig1    (trig1),
    .trig2    (trig2),
    .src_sel  (src_q),
    .edge_sel (edge_q),
    .trig_det (trig_det)
  );

  assign smp_c      = ~adc_clk;
  assign idle_c     = (state_q == IDLE) || (state_q == DONE);
  assign start_c    = cap_start && idle_c;
  assign dec_mask_c = (DCNT_W'(1) << dec_q) - DCNT_W'(1);
  assign store_c    = (state_q inside {PRE, ARMED, POST}) && smp_c && ((dec_cnt_q & dec_mask_c) == '0);
  assign p_c        = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
  // Pre-fill ends on the store that brings the count to DEPTH-P.
  assign pre_last_c = (({1'b0, cnt_q} + {1'b0, post_len_q} + (ADDR_W+1)'(1)) == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (cap_start) state_d = PRE;
      PRE:        if (store_c && pre_last_c) state_d = ARMED;
      ARMED:      if (trig_det) state_d = POST;
      POST:       if (store_c && (cnt_q == ADDR_W'(1))) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Capture datapath: config latch, decimation, write pointer and stage counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_clk    <= 1'b0;
      dec_cnt_q  <= '0;
      dec_q      <= '0;
      src_q      <= 1'b0;
      edge_q     <= EDGE_RISE;
      post_len_q <= ADDR_W'(1);
      wptr_q     <= '0;
      cnt_q      <= '0;
      st_en_q    <= 1'b0;
      st_addr_q  <= '0;
      trig_addr  <= '0;
      busy       <= 1'b0;
      cap_done   <= 1'b0;
    end else begin
      adc_clk   <= ~adc_clk;
      st_en_q   <= store_c;
      st_addr_q <= wptr_q;
      busy      <= state_d inside {PRE, ARMED, POST};
      cap_done  <= (state_d == DONE);

      if (start_c)    dec_cnt_q <= '0;
      else if (smp_c) dec_cnt_q <= dec_cnt_q + DCNT_W'(1);

      if (start_c) begin
        dec_q      <= decimator;
        src_q      <= trig_src;
        edge_q     <= trig_edge;
        post_len_q <= p_c;
        wptr_q     <= '0;
        cnt_q      <= '0;
      end else begin
        if (store_c) wptr_q <= wptr_q + ADDR_W'(1);
        case (state_q)
          PRE:     if (store_c) cnt_q <= cnt_q + ADDR_W'(1);
          ARMED:   if (trig_det) cnt_q <= post_len_q;
          POST:    if (store_c) cnt_q <= cnt_q - ADDR_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end

      // Next write address after the final store is the oldest sample.
      if ((state_q == POST) && (state_d == DONE)) trig_addr <= wptr_q + ADDR_W'(1);
    end
  end

  // The last post-trigger store lands in the first DONE cycle, so a store beats a read.
  assign ram_en   = st_en_q | (idle_c & rd_en);
  assign ram_we   = st_en_q;
  assign ram_addr = (idle_c && !st_en_q) ? rd_addr : st_addr_q;

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Directed bench for dso_capture_ctrl: reset, capture, early trigger, decimation, exclusion, reset in POST.
module tb_dso_capture_ctrl;
  import dso_cap_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              adc_clk;
  logic              trig1 = 1'b0, trig2 = 1'b1;
  logic              trig_src = 1'b0, trig_edge = 1'b1;
  logic [ADDR_W-1:0] trig_pos = '0;
  logic [DEC_W-1:0]  decimator = '0;
  logic              cap_start = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              busy, cap_done, ram_en, ram_we;
  logic [ADDR_W-1:0] trig_addr, ram_addr;

  int total = 0;
  int bad = 0;
  int nst = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  dso_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk),
    .trig1(trig1), .trig2(trig2), .trig_src(trig_src), .trig_edge(trig_edge),
    .trig_pos(trig_pos), .decimator(decimator), .cap_start(cap_start),
    .rd_en(rd_en), .rd_addr(rd_addr), .busy(busy), .cap_done(cap_done),
    .trig_addr(trig_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ram_we === 1'b1) nst++;
  endtask

  task automatic start_cap(input logic src, input logic edg, input int pos, input int dec);
    @(negedge clk);
    nst       = 0;
    trig_src  = src;
    trig_edge = edg;
    trig_pos  = ADDR_W'(pos);
    decimator = DEC_W'(dec);
    cap_start = 1'b1;
    @(negedge clk);
    cap_start = 1'b0;
  endtask

  // Returns at the negedge where the n-th store becomes visible on ram_we.
  task automatic wait_n(input int n);
    int guard = 0;
    while (nst < n && guard < 20000) begin
      tick();
      guard++;
    end
    if (nst < n) begin
      total++; bad++;
      $display("FAIL wait_stores got=%0d want=%0d", nst, n);
    end
  endtask

  // Caller changed the trigger input at this negedge; stores visible from the 5th
  // negedge on were decided after trig_det and are post-trigger stores.
  task automatic run_post(output int post);
    int k = 0;
    post = 0;
    while (k < 20000) begin
      tick();
      k++;
      if (k >= 5 && ram_we === 1'b1) post++;
      if (cap_done === 1'b1) break;
    end
    if (cap_done !== 1'b1) begin
      total++; bad++;
      $display("FAIL post_timeout cap_done=%b", cap_done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (adc_clk !== 1'b0) begin bad++; $display("FAIL rst_adc_clk got=%b want=0", adc_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL rst_cap_done got=%b want=0", cap_done); end
    total++; if (trig_addr !== 9'd0) begin bad++; $display("FAIL rst_trig_addr got=%0d want=0", trig_addr); end
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 9'd0) begin
      bad++; $display("FAIL rst_ram got=%b%b/%0h want=00/0", ram_en, ram_we, ram_addr); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (adc_clk !== ((i % 2) == 0)) begin
        bad++; $display("FAIL adc_clk_toggle[%0d] got=%b want=%b", i, adc_clk, (i % 2) == 0);
      end
    end
    rd_en = 1'b1; rd_addr = 9'h1A5;
    #1;
    total++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'h1A5) begin
      bad++; $display("FAIL rd_passthru got=%b%b/%0h want=10/1a5", ram_en, ram_we, ram_addr); end
    rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic test_basic();
    int post;
    trig1 = 1'b0;
    start_cap(1'b0, EDGE_RISE, 256, 0);
    wait_n(255);
    total++; if (dut.state_q !== PRE) begin bad++; $display("FAIL basic_pre255 got=%0d want=%0d", dut.state_q, PRE); end
    wait_n(256);
    total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL basic_armed256 got=%0d want=%0d", dut.state_q, ARMED); end
    wait_n(1000);
    trig1 = 1'b1;
    run_post(post);
    total++; if (post !== 256) begin bad++; $display("FAIL basic_post got=%0d want=256", post); end
    total++; if (nst !== 1258) begin bad++; $display("FAIL basic_total got=%0d want=1258", nst); end
    total++; if (trig_addr !== 9'd234) begin bad++; $display("FAIL basic_trig_addr got=%0d want=234", trig_addr); end
    tick();
    total++; if (cap_done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done got=%b/%b want=1/0", cap_done, busy); end
    trig1 = 1'b0;
  endtask

  task automatic test_early_trigger();
    int post;
    trig2 = 1'b1;
    start_cap(1'b1, EDGE_FALL, 100, 0);
    wait_n(50);
    trig2 = 1'b0;
    wait_n(100);
    trig2 = 1'b1;
    wait_n(412);
    total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL early_armed412 got=%0d want=%0d", dut.state_q, ARMED); end
    wait_n(500);
    total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL early_ignored got=%0d want=%0d", dut.state_q, ARMED); end
    trig2 = 1'b0;
    run_post(post);
    total++; if (post !== 100) begin bad++; $display("FAIL early_post got=%0d want=100", post); end
    total++; if (trig_addr !== 9'd90) begin bad++; $display("FAIL early_trig_addr got=%0d want=90", trig_addr); end
    trig2 = 1'b1;
  endtask

  task automatic test_decimation();
    int post, c0;
    trig1 = 1'b0;
    start_cap(1'b0, EDGE_RISE, 0, 3);
    wait_n(2); c0 = cyc;
    wait_n(3);
    total++; if (cyc - c0 !== 16) begin bad++; $display("FAIL dec_gap got=%0d want=16", cyc - c0); end
    decimator = '0;
    trig_pos  = 9'd200;
    wait_n(10); c0 = cyc;
    wait_n(11);
    total++; if (cyc - c0 !== 16) begin bad++; $display("FAIL dec_gap_held got=%0d want=16", cyc - c0); end
    wait_n(520);
    trig1 = 1'b1;
    run_post(post);
    total++; if (post !== 1) begin bad++; $display("FAIL dec_post got=%0d want=1", post); end
    total++; if (trig_addr !== 9'd9) begin bad++; $display("FAIL dec_trig_addr got=%0d want=9", trig_addr); end
    trig1 = 1'b0;
  endtask

  task automatic test_busy_exclusion();
    int post, nread, nidle;
    trig1 = 1'b0;
    start_cap(1'b0, EDGE_RISE, 256, 0);
    wait_n(254);
    trig1 = 1'b1;
    wait_n(256);
    nread = 0; nidle = 0;
    cap_start = 1'b1; rd_en = 1'b1; rd_addr = 9'h0F0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ram_en === 1'b1 && ram_we !== 1'b1) nread++;
      if (busy !== 1'b1) nidle++;
    end
    cap_start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    total++; if (nread !== 0) begin bad++; $display("FAIL excl_reads got=%0d want=0", nread); end
    total++; if (nidle !== 0) begin bad++; $display("FAIL excl_busy_low got=%0d want=0", nidle); end
    total++; if (dut.state_q !== ARMED) begin bad++; $display("FAIL excl_edge_trig got=%0d want=%0d", dut.state_q, ARMED); end
    total++; if (nst !== 276) begin bad++; $display("FAIL excl_stores got=%0d want=276", nst); end
    trig1 = 1'b0;
    wait_n(300);
    trig1 = 1'b1;
    run_post(post);
    total++; if (post !== 256) begin bad++; $display("FAIL excl_post got=%0d want=256", post); end
    total++; if (trig_addr !== 9'd46) begin bad++; $display("FAIL excl_trig_addr got=%0d want=46", trig_addr); end
    trig1 = 1'b0;
  endtask

  task automatic test_reset_in_post();
    int post;
    trig1 = 1'b0;
    start_cap(1'b0, EDGE_RISE, 100, 0);
    wait_n(450);
    trig1 = 1'b1;
    repeat (30) tick();
    total++; if (dut.state_q !== POST) begin bad++; $display("FAIL rip_in_post got=%0d want=%0d", dut.state_q, POST); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || cap_done !== 1'b0) begin
      bad++; $display("FAIL rip_flags got=%b/%b want=0/0", busy, cap_done); end
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin
      bad++; $display("FAIL rip_ram got=%b%b want=00", ram_en, ram_we); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL rip_state got=%0d want=%0d", dut.state_q, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    trig1 = 1'b0;
    repeat (4) tick();
    start_cap(1'b0, EDGE_RISE, 50, 0);
    wait_n(470);
    trig1 = 1'b1;
    run_post(post);
    total++; if (post !== 50) begin bad++; $display("FAIL rip_post got=%0d want=50", post); end
    total++; if (trig_addr !== 9'd10) begin bad++; $display("FAIL rip_trig_addr got=%0d want=10", trig_addr); end
    total++; if (cap_done !== 1'b1) begin bad++; $display("FAIL rip_done got=%b want=1", cap_done); end
    trig1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_trigger();
    test_decimation();
    test_busy_exclusion();
    test_reset_in_post();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
